alu_uart_ctrl: RTL

Byte-stream sequencer that drives the ALU operand and opcode registers from a UART receiver and returns the ALU result through a UART transmitter.
- Collects three received bytes in order: operand A, operand B, opcode.
- Presents them to the ALU, captures the result, then starts a single-byte transmission.
- Sits between the uart_rx/uart_tx blocks and the alu instance, replacing the switch/button loading path.
- Includes an inter-byte timeout and an overrun flag.

---
 rtl/alu_uart_ctrl_if.sv | 28 ++
 rtl/alu_uart_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/alu_uart_ctrl_if.sv
// Byte-stream bundle between the UART-fed sequencer and its environment
// (uart_rx/uart_tx and the ALU).
interface alu_uart_ctrl_if #(
    parameter int unsigned nb_data = 8
);
    logic [nb_data-1:0] rx_data;
    logic               rx_valid;
    logic               tx_done;
    logic [nb_data-1:0] alu_res;
    logic [nb_data-1:0] dato_a;
    logic [nb_data-1:0] dato_b;
    logic [nb_data-1:0] op;
    logic [nb_data-1:0] tx_data;
    logic               tx_start;
    logic               busy;
    logic               timeout;
    logic               overrun;

    modport master (
        input  rx_data, rx_valid, tx_done, alu_res,
        output dato_a, dato_b, op, tx_data, tx_start, busy, timeout, overrun
    );

    modport slave (
        output rx_data, rx_valid, tx_done, alu_res,
        input  dato_a, dato_b, op, tx_data, tx_start, busy, timeout, overrun
    );
endinterface

// File: rtl/alu_uart_ctrl.sv
// Collects operand A, operand B and opcode bytes from the UART receiver, drives the ALU,
// and sends the one-byte result back through the UART transmitter.
module alu_uart_ctrl #(
    parameter int unsigned nb_data        = 8,
    parameter int unsigned timeout_cycles = 1000000
) (
    input logic             i_clock,
    input logic             i_reset,
    alu_uart_ctrl_if.master bus
);
    localparam int unsigned nb_timer = $clog2(timeout_cycles + 1);
    localparam logic [nb_timer-1:0] timer_last = nb_timer'(timeout_cycles - 1);

    typedef enum logic [2:0] {
        StA,
        StB,
        StOp,
        StExec,
        StSend,
        StWait
    } state_e;

    state_e             state_q, state_d;
    logic [nb_timer-1:0] timer_q, timer_d;
    logic [nb_data-1:0] dato_a_q, dato_b_q, op_q, tx_data_q;
    logic               timeout_q, overrun_q;
    logic               load_a, load_b, load_op, load_res, expire, busy;

    always_comb begin
        state_d  = state_q;
        load_a   = 1'b0;
        load_b   = 1'b0;
        load_op  = 1'b0;
        load_res = 1'b0;
        expire   = 1'b0;
        case (state_q)
            StA: begin
                if (bus.rx_valid) begin
                    load_a  = 1'b1;
                    state_d = StB;
                end
            end
            StB: begin
                if (bus.rx_valid) begin
                    load_b  = 1'b1;
                    state_d = StOp;
                end else if (timer_q == timer_last) begin
                    expire  = 1'b1;
                    state_d = StA;
                end
            end
            StOp: begin
                if (bus.rx_valid) begin
                    load_op = 1'b1;
                    state_d = StExec;
                end else if (timer_q == timer_last) begin
                    expire  = 1'b1;
                    state_d = StA;
                end
            end
            StExec: begin
                load_res = 1'b1;
                state_d  = StSend;
            end
            StSend: state_d = StWait;
            StWait: begin
                if (bus.tx_done) begin
                    state_d = StA;
                end
            end
            default: state_d = StA;
        endcase
    end

    assign busy = (state_q == StExec) || (state_q == StSend) || (state_q == StWait);

    // Timer only runs while a frame is partially received; any byte or state change restarts it.
    always_comb begin
        timer_d = timer_q;
        if ((state_d != state_q) || bus.rx_valid) begin
            timer_d = '0;
        end else if ((state_q == StB) || (state_q == StOp)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= StA;
            timer_q   <= '0;
            dato_a_q  <= '0;
            dato_b_q  <= '0;
            op_q      <= '0;
            tx_data_q <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            timeout_q <= expire;
            if (load_a) begin
                dato_a_q <= bus.rx_data;
            end
            if (load_b) begin
                dato_b_q <= bus.rx_data;
            end
            if (load_op) begin
                op_q <= bus.rx_data;
            end
            if (load_res) begin
                tx_data_q <= bus.alu_res;
            end
            if (bus.rx_valid && busy) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.dato_a   = dato_a_q;
    assign bus.dato_b   = dato_b_q;
    assign bus.op       = op_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = (state_q == StSend);
    assign bus.busy     = busy;
    assign bus.timeout  = timeout_q;
    assign bus.overrun  = overrun_q;
endmodule
